// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down-counter/timer and its up-counter sibling.
//   DefaultWidth : counter width shared with the 4-bit up-counter
//   state_e      : timer FSM encoding (IDLE / RUN / DONE)
package down_counter_timer_pkg;

    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer.
//   master : drives clear, load, load_value, auto_reload, enable, tick_in;
//            observes count_out, borrow_out, busy, done
//   slave  : the timer itself (opposite directions)
interface down_counter_timer_if
    import down_counter_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             auto_reload;
    logic             enable;
    logic             tick_in;
    logic [WIDTH-1:0] count_out;
    logic             borrow_out;
    logic             busy;
    logic             done;

    modport master (
        output clear, load, load_value, auto_reload, enable, tick_in,
        input  count_out, borrow_out, busy, done
    );

    modport slave (
        input  clear, load, load_value, auto_reload, enable, tick_in,
        output count_out, borrow_out, busy, done
    );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable, cascadable down-counter/timer with one-shot and auto-reload modes.
// Ports:
//   clock : rising-edge system clock
//   reset : asynchronous, active-high reset
//   bus   : down_counter_timer_if.slave
//           clear (sync abort), load/load_value (start value), auto_reload,
//           enable & tick_in (count qualifier), count_out, borrow_out (one-cycle
//           terminal-count pulse), busy (RUN), done (sticky one-shot expiry)
// Priority on each edge: clear > load > decrement. All outputs are registered.
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input logic                  clock,
    input logic                  reset,
    down_counter_timer_if.slave  bus
);

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;

    logic step;
    assign step = (state_q == StRun) && bus.enable && bus.tick_in;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            count_q  <= '0;
            reload_q <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // Borrow is a single-cycle pulse; only a terminal step re-asserts it.
            borrow_q <= 1'b0;
            if (bus.clear) begin
                state_q <= StIdle;
                count_q <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else if (bus.load) begin
                reload_q <= bus.load_value;
                count_q  <= bus.load_value;
                done_q   <= 1'b0;
                if (bus.load_value != '0) begin
                    state_q <= StRun;
                    busy_q  <= 1'b1;
                end else begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            end else if (step) begin
                if (count_q > WIDTH'(1)) begin
                    count_q <= count_q - WIDTH'(1);
                end else begin
                    // Terminal step. A zero count in RUN is unreachable; treating it
                    // as terminal keeps the counter from ever wrapping below zero.
                    borrow_q <= 1'b1;
                    if (bus.auto_reload) begin
                        count_q <= reload_q;
                    end else begin
                        count_q <= '0;
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.count_out  = count_q;
    assign bus.borrow_out = borrow_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer (WIDTH=4).
module tb_down_counter_timer;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    down_counter_timer_if #(.WIDTH(4)) bus ();

    down_counter_timer #(.WIDTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge; inputs are changed and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clear       = 1'b0;
        bus.load        = 1'b0;
        bus.load_value  = 4'd0;
        bus.auto_reload = 1'b0;
        bus.enable      = 1'b0;
        bus.tick_in     = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #3;
        checks++;
        if (bus.count_out !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.borrow_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_init: count=%0d busy=%b done=%b borrow=%b, want 0 0 0 0",
                     bus.count_out, bus.busy, bus.done, bus.borrow_out);
        end
        #1 reset = 1'b0;
        // Mid-count reset: load 5, two ticks -> 3, then reset between edges.
        bus.enable     = 1'b1;
        bus.tick_in    = 1'b1;
        bus.load       = 1'b1;
        bus.load_value = 4'd5;
        step();
        bus.load = 1'b0;
        step();
        step();
        checks++;
        if (bus.count_out !== 4'd3 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_precount: count=%0d busy=%b, want 3 1",
                     bus.count_out, bus.busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.count_out !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.borrow_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: count=%0d busy=%b done=%b borrow=%b, want 0 0 0 0",
                     bus.count_out, bus.busy, bus.done, bus.borrow_out);
        end
        #1 reset = 1'b0;
        idle_inputs();
        step();
        checks++;
        if (bus.count_out !== 4'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_stays_idle: count=%0d busy=%b, want 0 0",
                     bus.count_out, bus.busy);
        end
    endtask

    task automatic test_one_shot();
        logic [3:0] exp_cnt [3] = '{4'd2, 4'd1, 4'd0};
        logic       exp_brw [3] = '{1'b0, 1'b0, 1'b1};
        idle_inputs();
        bus.enable     = 1'b1;
        bus.tick_in    = 1'b1;
        bus.load       = 1'b1;
        bus.load_value = 4'd3;
        step();
        bus.load = 1'b0;
        checks++;
        if (bus.count_out !== 4'd3 || bus.busy !== 1'b1 || bus.borrow_out !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_load: count=%0d busy=%b borrow=%b, want 3 1 0",
                     bus.count_out, bus.busy, bus.borrow_out);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.count_out !== exp_cnt[i] || bus.borrow_out !== exp_brw[i]) begin
                failures++;
                $display("FAIL oneshot_step%0d: count=%0d borrow=%b, want %0d %b", i,
                         bus.count_out, bus.borrow_out, exp_cnt[i], exp_brw[i]);
            end
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_done: done=%b busy=%b, want 1 0", bus.done, bus.busy);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.count_out !== 4'd0 || bus.borrow_out !== 1'b0 || bus.done !== 1'b1) begin
                failures++;
                $display("FAIL oneshot_hold%0d: count=%0d borrow=%b done=%b, want 0 0 1", i,
                         bus.count_out, bus.borrow_out, bus.done);
            end
        end
    endtask

    task automatic test_auto_reload();
        int last_borrow;
        int pulses;
        logic [3:0] exp_cnt;
        idle_inputs();
        bus.auto_reload = 1'b1;
        bus.enable      = 1'b1;
        bus.tick_in     = 1'b1;
        bus.load        = 1'b1;
        bus.load_value  = 4'd4;
        step();
        bus.load = 1'b0;
        checks++;
        if (bus.count_out !== 4'd4 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reload_load: count=%0d done=%b, want 4 0", bus.count_out, bus.done);
        end
        last_borrow = 0;
        pulses      = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            exp_cnt = (i % 4 == 0) ? 4'd4 : 4'(4 - (i % 4));
            checks++;
            if (bus.count_out !== exp_cnt || bus.borrow_out !== (i % 4 == 0) ||
                bus.done !== 1'b0) begin
                failures++;
                $display("FAIL reload_step%0d: count=%0d borrow=%b done=%b, want %0d %b 0", i,
                         bus.count_out, bus.borrow_out, bus.done, exp_cnt, (i % 4 == 0));
            end
            if (bus.borrow_out === 1'b1) begin
                checks++;
                if (i - last_borrow !== 4) begin
                    failures++;
                    $display("FAIL reload_period: got %0d cycles, want 4", i - last_borrow);
                end
                last_borrow = i;
                pulses++;
            end
        end
        checks++;
        if (pulses !== 5) begin
            failures++;
            $display("FAIL reload_pulses: got %0d, want 5", pulses);
        end
    endtask

    task automatic test_gated_ticks();
        logic [3:0] exp_cnt;
        idle_inputs();
        do_clear();
        bus.enable     = 1'b1;
        bus.load       = 1'b1;
        bus.load_value = 4'd2;
        step();
        bus.load = 1'b0;
        // Ticks on cycles 16, 32, 48; enable is off for the first, so decrements at 32, 48.
        for (int c = 1; c <= 48; c++) begin
            bus.tick_in = (c % 16 == 0);
            bus.enable  = (c != 16);
            step();
            exp_cnt = (c < 32) ? 4'd2 : (c < 48) ? 4'd1 : 4'd0;
            checks++;
            if (bus.count_out !== exp_cnt || bus.borrow_out !== (c == 48)) begin
                failures++;
                $display("FAIL gated_c%0d: count=%0d borrow=%b, want %0d %b", c,
                         bus.count_out, bus.borrow_out, exp_cnt, (c == 48));
            end
        end
        bus.tick_in = 1'b0;
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL gated_done: done=%b, want 1", bus.done);
        end
    endtask

    task automatic test_priority();
        idle_inputs();
        do_clear();
        bus.enable     = 1'b1;
        bus.tick_in    = 1'b1;
        bus.load       = 1'b1;
        bus.load_value = 4'd2;
        step();
        bus.load = 1'b0;
        step();
        checks++;
        if (bus.count_out !== 4'd1) begin
            failures++;
            $display("FAIL prio_setup: count=%0d, want 1", bus.count_out);
        end
        // Load coincides with what would be the terminal step.
        bus.load       = 1'b1;
        bus.load_value = 4'd9;
        step();
        checks++;
        if (bus.count_out !== 4'd9 || bus.borrow_out !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL prio_load: count=%0d borrow=%b busy=%b, want 9 0 1",
                     bus.count_out, bus.borrow_out, bus.busy);
        end
        bus.clear      = 1'b1;
        bus.load_value = 4'd5;
        step();
        bus.clear = 1'b0;
        bus.load  = 1'b0;
        checks++;
        if (bus.count_out !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.borrow_out !== 1'b0) begin
            failures++;
            $display("FAIL prio_clear: count=%0d busy=%b done=%b borrow=%b, want 0 0 0 0",
                     bus.count_out, bus.busy, bus.done, bus.borrow_out);
        end
        step();
        checks++;
        if (bus.count_out !== 4'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL prio_idle_hold: count=%0d busy=%b, want 0 0",
                     bus.count_out, bus.busy);
        end
    endtask

    task automatic test_edge_values();
        int pulses;
        idle_inputs();
        bus.enable     = 1'b1;
        bus.tick_in    = 1'b1;
        bus.load       = 1'b1;
        bus.load_value = 4'd15;
        step();
        bus.load = 1'b0;
        checks++;
        if (bus.count_out !== 4'd15) begin
            failures++;
            $display("FAIL max_load: count=%0d, want 15", bus.count_out);
        end
        pulses = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            checks++;
            if (bus.count_out !== 4'(15 - i) || bus.borrow_out !== (i == 15)) begin
                failures++;
                $display("FAIL max_step%0d: count=%0d borrow=%b, want %0d %b", i,
                         bus.count_out, bus.borrow_out, 15 - i, (i == 15));
            end
            if (bus.borrow_out === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL max_summary: pulses=%0d done=%b, want 1 1", pulses, bus.done);
        end
        bus.load       = 1'b1;
        bus.load_value = 4'd0;
        step();
        bus.load = 1'b0;
        checks++;
        if (bus.count_out !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.borrow_out !== 1'b0) begin
            failures++;
            $display("FAIL zero_load: count=%0d busy=%b done=%b borrow=%b, want 0 0 0 0",
                     bus.count_out, bus.busy, bus.done, bus.borrow_out);
        end
        step();
        checks++;
        if (bus.count_out !== 4'd0 || bus.busy !== 1'b0 || bus.borrow_out !== 1'b0) begin
            failures++;
            $display("FAIL zero_hold: count=%0d busy=%b borrow=%b, want 0 0 0",
                     bus.count_out, bus.busy, bus.borrow_out);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_gated_ticks();
        test_priority();
        test_edge_values();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
